// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: shared constants for the timer bank.
//   - mode bit indices for the per-channel mode register
//   - command opcodes written to the global command register
//   - register offsets inside a channel window and the global window
//   - helper that names the global window's channel number
package timer_bank_pkg;

  // Mode register bits
  localparam int MODE_W        = 5;
  localparam int MODE_UP       = 0;  // 1: count up toward load, 0: count down to 0
  localparam int MODE_PERIODIC = 1;  // reload on TC instead of disarming
  localparam int MODE_GATE     = 2;  // count only while gate input is high
  localparam int MODE_TOGGLE   = 3;  // toggle out on TC instead of setting it
  localparam int MODE_PRESCALE = 4;  // advance on prescaler tick instead of every clk

  // Command opcodes
  localparam logic [2:0] OP_ARM       = 3'd0;
  localparam logic [2:0] OP_DISARM    = 3'd1;
  localparam logic [2:0] OP_LOAD      = 3'd2;
  localparam logic [2:0] OP_HOLD      = 3'd3;
  localparam logic [2:0] OP_LOAD_ARM  = 3'd4;
  localparam logic [2:0] OP_CLR_OUT   = 3'd5;
  localparam logic [2:0] OP_SET_OUT   = 3'd6;
  localparam logic [2:0] OP_RESET     = 3'd7;

  // Channel window register offsets
  localparam logic [1:0] REG_MODE  = 2'd0;
  localparam logic [1:0] REG_LOAD  = 2'd1;
  localparam logic [1:0] REG_HOLD  = 2'd2;
  localparam logic [1:0] REG_COUNT = 2'd3;

  // Global window register offsets
  localparam logic [1:0] REG_CMD      = 2'd0;
  localparam logic [1:0] REG_PRESCALE = 2'd1;
  localparam logic [1:0] REG_IRQ_EN   = 2'd2;
  localparam logic [1:0] REG_PENDING  = 2'd3;

  // The global window sits directly above the last channel.
  function automatic int unsigned global_chan(input int unsigned nchan);
    return nchan;
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// timer_bank_if: CPU register bus of the timer bank.
//   cs/wr/rd/addr/wdata : driven by the bus master
//   rdata               : registered read data from the timer bank
// Bus semantics: there is no valid/ready handshake. A write is the single
// cycle where cs&wr is high at a clk edge; it always completes at that edge.
// A read is the single cycle where cs&rd is high; rdata carries the result
// from the following cycle and holds until the next read. No back-pressure.
interface timer_bank_if #(
  parameter int NCHAN = 5,
  parameter int WIDTH = 16
);
  localparam int AW = $clog2(NCHAN + 1) + 2;

  logic             cs;
  logic             wr;
  logic             rd;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

  modport master (output cs, wr, rd, addr, wdata, input rdata);
  modport slave  (input cs, wr, rd, addr, wdata, output rdata);
endinterface

// File: rtl/timer_bank_chan.sv
// timer_bank_chan: one counter/timer channel.
//   clk, reset  : clock, asynchronous active-high reset
//   pre_tick    : shared prescaler tick
//   gate        : count enable (used when mode gate bit set)
//   wr_en       : bus write addressed to this channel's window
//   reg_sel     : register offset for write and read mux
//   wdata       : bus write data
//   cmd_en      : global command selects this channel (mask bit set)
//   cmd_op      : command opcode
//   rd_data     : read mux output for reg_sel
//   out         : channel output
//   tc          : terminal count reached at this clk edge
module timer_bank_chan
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pre_tick,
  input  logic             gate,
  input  logic             wr_en,
  input  logic [1:0]       reg_sel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cmd_en,
  input  logic [2:0]       cmd_op,
  output logic [WIDTH-1:0] rd_data,
  output logic             out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [MODE_W-1:0] mode_q, mode_d;
  logic [WIDTH-1:0]  load_q, load_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              armed_q, armed_d;
  logic              out_q, out_d;
  logic              tick;
  logic              advance;

  always_comb begin
    mode_d  = mode_q;
    load_d  = load_q;
    hold_d  = hold_q;
    count_d = count_q;
    armed_d = armed_q;
    out_d   = out_q;
    tc      = 1'b0;

    tick    = mode_q[MODE_PRESCALE] ? pre_tick : 1'b1;
    advance = armed_q && (gate || !mode_q[MODE_GATE]) && tick;

    // Any bus access to this channel (register write or command) takes the
    // edge; a tick landing on the same edge is dropped for this channel.
    if (wr_en) begin
      case (reg_sel)
        REG_MODE:  mode_d  = MODE_W'(wdata);
        REG_LOAD:  load_d  = wdata;
        REG_COUNT: count_d = wdata;
        default:   ;  // hold is a read-only snapshot
      endcase
    end else if (cmd_en) begin
      case (cmd_op)
        OP_ARM:      armed_d = 1'b1;
        OP_DISARM:   armed_d = 1'b0;
        OP_LOAD:     count_d = load_q;
        OP_HOLD:     hold_d  = count_q;
        OP_LOAD_ARM: begin
          count_d = load_q;
          armed_d = 1'b1;
        end
        OP_CLR_OUT:  out_d = 1'b0;
        OP_SET_OUT:  out_d = 1'b1;
        default: begin  // OP_RESET
          mode_d  = '0;
          load_d  = '0;
          hold_d  = '0;
          count_d = '0;
          armed_d = 1'b0;
          out_d   = 1'b0;
        end
      endcase
    end else if (advance) begin
      if (mode_q[MODE_UP]) begin
        if (count_q == load_q) begin
          tc = 1'b1;
          if (mode_q[MODE_PERIODIC]) count_d = '0;
          else                       armed_d = 1'b0;
        end else begin
          count_d = count_q + ONE;  // wraps naturally at all-ones
        end
      end else begin
        if (count_q == '0) begin
          tc = 1'b1;
          if (mode_q[MODE_PERIODIC]) count_d = load_q;
          else                       armed_d = 1'b0;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end

    if (tc) out_d = mode_q[MODE_TOGGLE] ? ~out_q : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= '0;
      load_q  <= '0;
      hold_q  <= '0;
      count_q <= '0;
      armed_q <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      load_q  <= load_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      armed_q <= armed_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_MODE:  rd_data = WIDTH'(mode_q);
      REG_LOAD:  rd_data = load_q;
      REG_HOLD:  rd_data = hold_q;
      default:   rd_data = count_q;
    endcase
  end

  assign out = out_q;

endmodule

// File: rtl/timer_bank.sv
// timer_bank: NCHAN-channel counter/timer bank with shared prescaler.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : register bus (timer_bank_if.slave), addr = {chan, reg}
//   gate       : per-channel count enables (already synchronised)
//   out        : channel outputs
//   irq        : OR of enabled pending TC flags
// Optional feature macro TIMER_BANK_IRQ_EN: when defined, the irq enable and
// pending registers, the status pending field and irq are implemented; when
// undefined they read 0, writes to them are ignored and irq is tied low.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int NCHAN = 5,
  parameter int WIDTH = 16,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  timer_bank_if.slave      bus,
  input  logic [NCHAN-1:0] gate,
  output logic [NCHAN-1:0] out,
  output logic             irq
);

  localparam int AW = $clog2(NCHAN + 1) + 2;
  localparam int CW = AW - 2;
  localparam logic [CW-1:0] GLOBAL_SEL = CW'(global_chan(NCHAN));

  logic [CW-1:0]    a_chan;
  logic [1:0]       a_reg;
  logic             wr_stb, rd_stb, glob_sel, cmd_wr;
  logic [2:0]       cmd_op;
  logic [NCHAN-1:0] cmd_mask;
  logic [NCHAN-1:0] tc_vec;
  logic [WIDTH-1:0] chan_rdata [NCHAN];

  assign a_chan   = bus.addr[AW-1:2];
  assign a_reg    = bus.addr[1:0];
  assign wr_stb   = bus.cs & bus.wr;
  assign rd_stb   = bus.cs & bus.rd;
  assign glob_sel = (a_chan == GLOBAL_SEL);
  assign cmd_wr   = wr_stb & glob_sel & (a_reg == REG_CMD);
  assign cmd_op   = bus.wdata[NCHAN+2:NCHAN];
  assign cmd_mask = bus.wdata[NCHAN-1:0];

  // Prescaler
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             pre_tick;

  always_comb begin
    pre_tick   = (pre_cnt_q == prescale_q);
    prescale_d = prescale_q;
    pre_cnt_d  = pre_tick ? '0 : pre_cnt_q + PRE_W'(1);
    // Writing prescale restarts the phase so the first tick is a full period away.
    if (wr_stb && glob_sel && (a_reg == REG_PRESCALE)) begin
      prescale_d = PRE_W'(bus.wdata);
      pre_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q  <= '0;
      prescale_q <= '0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      prescale_q <= prescale_d;
    end
  end

  // Channels
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    timer_bank_chan #(.WIDTH(WIDTH)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .pre_tick (pre_tick),
      .gate     (gate[c]),
      .wr_en    (wr_stb && (a_chan == CW'(c))),
      .reg_sel  (a_reg),
      .wdata    (bus.wdata),
      .cmd_en   (cmd_wr && cmd_mask[c]),
      .cmd_op   (cmd_op),
      .rd_data  (chan_rdata[c]),
      .out      (out[c]),
      .tc       (tc_vec[c])
    );
  end

  // Interrupt enable / pending
  logic [NCHAN-1:0] en_rd, pend_rd;

`ifdef TIMER_BANK_IRQ_EN
  logic [NCHAN-1:0] en_q, en_d, pend_q, pend_d;

  always_comb begin
    en_d   = en_q;
    pend_d = pend_q;
    if (wr_stb && glob_sel && (a_reg == REG_IRQ_EN)) en_d = bus.wdata[NCHAN-1:0];
    if (wr_stb && glob_sel && (a_reg == REG_PENDING)) pend_d = pend_q & ~bus.wdata[NCHAN-1:0];
    // Applied after the clear so a TC on the same edge keeps its flag.
    pend_d = pend_d | tc_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q   <= '0;
      pend_q <= '0;
    end else begin
      en_q   <= en_d;
      pend_q <= pend_d;
    end
  end

  assign en_rd   = en_q;
  assign pend_rd = pend_q;
  assign irq     = |(pend_q & en_q);
`else
  logic unused_tc;
  assign unused_tc = ^tc_vec;
  assign en_rd     = '0;
  assign pend_rd   = '0;
  assign irq       = 1'b0;
`endif

  // Read data register
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (a_chan == CW'(c)) rd_mux = chan_rdata[c];
    end
    if (glob_sel) begin
      case (a_reg)
        REG_CMD:      rd_mux = WIDTH'({pend_rd, out});
        REG_PRESCALE: rd_mux = WIDTH'(prescale_q);
        REG_IRQ_EN:   rd_mux = WIDTH'(en_rd);
        default:      rd_mux = WIDTH'(pend_rd);
      endcase
    end
    rdata_d = rd_stb ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed bench for timer_bank (NCHAN=5, WIDTH=16, PRE_W=8).
// All inputs change on the falling edge; outputs are sampled there too.
module tb_timer_bank;

`ifdef TIMER_BANK_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  localparam int G = 5;  // global window channel number

  logic       clk;
  logic       reset;
  logic [4:0] gate;
  logic [4:0] out;
  logic       irq;

  int n_checks = 0;
  int n_err    = 0;

  timer_bank_if #(.NCHAN(5), .WIDTH(16)) bus_if ();

  timer_bank #(.NCHAN(5), .WIDTH(16), .PRE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .gate  (gate),
    .out   (out),
    .irq   (irq)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] a(input int ch, input int r);
    return 5'(ch * 4 + r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Driver tasks: called at a falling edge, return at the next falling edge.
  task automatic wr(input logic [4:0] addr, input logic [15:0] data);
    bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.rd = 1'b0;
    bus_if.addr = addr; bus_if.wdata = data;
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.wr = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, output logic [15:0] data);
    bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.wr = 1'b0;
    bus_if.addr = addr;
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.rd = 1'b0;
    data = bus_if.rdata;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [15:0] v;

  initial begin
    reset = 1'b1; gate = '0;
    bus_if.cs = 1'b0; bus_if.wr = 1'b0; bus_if.rd = 1'b0;
    bus_if.addr = '0; bus_if.wdata = '0;
    wait_cyc(3);
    reset = 1'b0;

    // Reset state
    check("rst_rdata", bus_if.rdata, 0);
    check("rst_out", out, 0);
    check("rst_irq", irq, 0);
    rd(a(G, 0), v); check("rst_status", v, 0);

    // Ch1: down, periodic, toggle, every clk, load=3 -> TC every 4 clks
    wr(a(1, 0), 16'd10);
    wr(a(1, 1), 16'd3);
    wr(a(G, 2), 16'h02);             // enable[1]
    wr(a(G, 0), 16'd130);            // op4 mask ch1
    wait_cyc(3); check("a_out_before_tc", out[1], 0);
    wait_cyc(1); check("a_tc1_out", out[1], 1);
    check("a_tc1_irq", irq, IRQ_ON);
    wr(a(G, 3), 16'h02);             // W1C pending[1]
    check("a_w1c_irq", irq, 0);
    wait_cyc(2); check("a_out_before_tc2", out[1], 1);
    wr(a(G, 3), 16'h02);             // W1C on the TC edge: set wins
    check("a_tc2_out", out[1], 0);
    check("a_setwins_irq", irq, IRQ_ON);
    wr(a(G, 0), 16'd98);             // op3 hold ch1 (count=3 at this edge)
    rd(a(1, 2), v); check("a_hold", v, 3);
    wr(a(G, 0), 16'd34);             // op1 disarm ch1
    rd(a(1, 3), v); check("a_count_after_disarm", v, 2);
    rd(a(G, 3), v); check("a_pending", v, IRQ_ON ? 2 : 0);
    rd(a(G, 0), v); check("a_status", v, IRQ_ON ? 64 : 0);
    wr(a(G, 3), 16'h1f);

    // Ch2: up, one-shot, toggle, load=5 -> one toggle after 6 ticks, holds 5
    wr(a(2, 0), 16'd9);
    wr(a(2, 1), 16'd5);
    wr(a(G, 0), 16'd4);              // op0 arm ch2
    wait_cyc(5); check("b_out_before_tc", out[2], 0);
    wait_cyc(1); check("b_tc_out", out[2], 1);
    wait_cyc(4); check("b_toggle_once", out[2], 1);
    rd(a(2, 3), v); check("b_count_holds", v, 5);
    check("b_irq_masked", irq, 0);
    rd(a(G, 0), v); check("b_status", v, IRQ_ON ? 132 : 4);

    // Ch3: prescale=2, down, periodic, toggle, load=1 -> TC every 6 clks
    wr(a(3, 0), 16'd26);
    wr(a(3, 1), 16'd1);
    wr(a(G, 1), 16'd2);
    wr(a(G, 0), 16'd136);            // op4 mask ch3
    wait_cyc(4); check("c_out_before_tc", out[3], 0);
    wait_cyc(1); check("c_tc1_out", out[3], 1);
    wait_cyc(5); check("c_out_between", out[3], 1);
    wait_cyc(1); check("c_tc2_out", out[3], 0);
    wr(a(G, 1), 16'd2);              // rewrite prescale: phase restarts
    wait_cyc(5); check("c_no_early_tc", out[3], 0);
    wait_cyc(1); check("c_tc_after_rephase", out[3], 1);
    wr(a(G, 0), 16'd40);             // op1 disarm ch3

    // Ch0: gated down counter, load=100
    wr(a(0, 0), 16'd4);
    wr(a(0, 1), 16'd100);
    wr(a(G, 0), 16'd129);            // op4 mask ch0
    wait_cyc(10);
    rd(a(0, 3), v); check("d_frozen", v, 100);
    gate = 5'b00001;
    wait_cyc(5);
    rd(a(0, 3), v); check("d_counting", v, 95);
    gate = 5'b00000;
    rd(a(0, 3), v); check("d_refrozen", v, 94);

    // Ch4: load=0 one-shot down -> TC on first tick
    wr(a(G, 0), 16'd144);            // op4 mask ch4
    wait_cyc(1); check("e_load0_tc", out[4], 1);
    check("e_out_all", out, 28);

    // Ch4: count write on a tick edge wins
    wr(a(4, 1), 16'd50);
    wr(a(G, 0), 16'd144);
    wait_cyc(3);
    wr(a(4, 3), 16'h1234);
    rd(a(4, 3), v); check("e_write_wins", v, 16'h1234);
    rd(a(4, 3), v); check("e_counts_on", v, 16'h1233);
    rd(a(7, 0), v); check("e_unmapped", v, 0);
    rd(a(G, 1), v); check("e_prescale_rd", v, 2);

    // Reset mid-count
    check("r_out_before", out, 28);
    reset = 1'b1;
    #1;
    check("r_out", out, 0);
    check("r_irq", irq, 0);
    check("r_rdata", bus_if.rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_cyc(3);
    rd(a(4, 3), v); check("r_count_no_resume", v, 0);
    rd(a(2, 1), v); check("r_load_cleared", v, 0);
    rd(a(G, 1), v); check("r_prescale_cleared", v, 0);
    rd(a(G, 0), v); check("r_status", v, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
